// File: rtl/tdpram_pkg.sv
// Shared types for the byte-wise true dual-port RAM.
// Clear FSM states and same-port read-during-write modes.
package tdpram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } tdpram_state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/tdpram_port.sv
// One RAM port: lane write enables, RDW merge, read register.
// Optional output stage when TDPRAM_OUT_REG_EN is defined.
module tdpram_port
  import tdpram_pkg::*;
#(
  parameter int BYTE_WIDTH = 8,
  parameter int BYTES      = 4,
  parameter int RDW_MODE   = RDW_OLD,
  localparam int W         = BYTES * BYTE_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ready_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [BYTES-1:0] be_i,
  input  logic [W-1:0]     wdata_i,
  input  logic [W-1:0]     mem_i,
  output logic [BYTES-1:0] lane_we_o,
  output logic [W-1:0]     rdata_o,
  output logic             rvalid_o
);

  logic         acc;
  logic         wr;
  logic [W-1:0] merged;
  logic [W-1:0] rdata_d;
  logic [W-1:0] rdata_q;
  logic         rvalid_q;

  assign acc       = ready_i & en_i;
  assign wr        = acc & we_i;
  assign lane_we_o = be_i & {BYTES{wr}};

  always_comb begin
    merged = mem_i;
    for (int i = 0; i < BYTES; i++) begin
      if (be_i[i])
        merged[i*BYTE_WIDTH +: BYTE_WIDTH] =
          wdata_i[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  assign rdata_d = (RDW_MODE == RDW_NEW && wr)
                 ? merged : mem_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= acc;
      if (acc)
        rdata_q <= rdata_d;
    end
  end

`ifdef TDPRAM_OUT_REG_EN
  logic [W-1:0] rdata_o_q;
  logic         rvalid_o_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_o_q  <= '0;
      rvalid_o_q <= 1'b0;
    end else begin
      rvalid_o_q <= rvalid_q;
      if (rvalid_q)
        rdata_o_q <= rdata_q;
    end
  end

  assign rdata_o  = rdata_o_q;
  assign rvalid_o = rvalid_o_q;
`else
  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
`endif

endmodule

// File: rtl/bytewise_tdp_ram.sv
// Byte-lane true dual-port RAM with self-clearing FSM.
// TDPRAM_OUT_REG_EN adds one output register stage per port.
module bytewise_tdp_ram
  import tdpram_pkg::*;
#(
  parameter int BYTE_WIDTH = 8,
  parameter int BYTES      = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int RDW_MODE   = RDW_OLD,
  localparam int W         = BYTES * BYTE_WIDTH,
  localparam int DEPTH     = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  init_busy,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [BYTES-1:0]      a_be,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [W-1:0]          a_wdata,
  output logic [W-1:0]          a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_en,
  input  logic                  b_we,
  input  logic [BYTES-1:0]      b_be,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [W-1:0]          b_wdata,
  output logic [W-1:0]          b_rdata,
  output logic                  b_rvalid,
  output logic                  col_err
);

  logic [BYTES-1:0][BYTE_WIDTH-1:0] mem_q [DEPTH];

  tdpram_state_e         state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  col_err_d;
  logic                  col_err_q;
  logic                  ready;
  logic [BYTES-1:0]      a_lwe;
  logic [BYTES-1:0]      b_lwe;

  assign ready     = (state_q == READY);
  assign init_busy = ~ready;
  assign col_err   = col_err_q;
  assign col_err_d = (a_addr == b_addr) & |(a_lwe & b_lwe);

  tdpram_port #(
    .BYTE_WIDTH(BYTE_WIDTH),
    .BYTES     (BYTES),
    .RDW_MODE  (RDW_MODE)
  ) u_port_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready_i  (ready),
    .en_i     (a_en),
    .we_i     (a_we),
    .be_i     (a_be),
    .wdata_i  (a_wdata),
    .mem_i    (mem_q[a_addr]),
    .lane_we_o(a_lwe),
    .rdata_o  (a_rdata),
    .rvalid_o (a_rvalid)
  );

  tdpram_port #(
    .BYTE_WIDTH(BYTE_WIDTH),
    .BYTES     (BYTES),
    .RDW_MODE  (RDW_MODE)
  ) u_port_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready_i  (ready),
    .en_i     (b_en),
    .we_i     (b_we),
    .be_i     (b_be),
    .wdata_i  (b_wdata),
    .mem_i    (mem_q[b_addr]),
    .lane_we_o(b_lwe),
    .rdata_o  (b_rdata),
    .rvalid_o (b_rvalid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      col_err_q <= 1'b0;
    end else begin
      col_err_q <= col_err_d;
      unique case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (&cnt_q)
            state_q <= READY;
        end
        READY: begin
          if (clr_req) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Port A lanes are written last so they win on shared lanes.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < BYTES; i++)
        if (b_lwe[i])
          mem_q[b_addr][i] <= b_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      for (int i = 0; i < BYTES; i++)
        if (a_lwe[i])
          mem_q[a_addr][i] <= a_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

endmodule
